// File: rtl/divisor_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int WIDTH_MAX = 16;

    // Bits needed for the step counter, which runs from WIDTH-1 down to 0.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/divisor_sequencial_if.sv
// Operand/result bundle between the entry stage, the divider and the display stage.
interface divisor_sequencial_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Enable;
    logic             Strobe;
    logic [WIDTH-1:0] Asig;
    logic [WIDTH-1:0] Bsig;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] QD;
    logic [WIDTH-1:0] RD;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output A, B, Enable, Strobe,
        input  Asig, Bsig, Q, R, QD, RD, Busy, Done, DivZero
    );

    modport slave (
        input  A, B, Enable, Strobe,
        output Asig, Bsig, Q, R, QD, RD, Busy, Done, DivZero
    );
endinterface

// File: rtl/divisor_passo.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the result bit into the quotient.
module divisor_passo #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // One bit wider than rem so a remainder just below a large divisor cannot wrap.
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        // When it fits the true difference is below the divisor, so the low bits are exact.
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_n   = fits ? diff : shifted[WIDTH-1:0];
        quo_n   = {quo[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: captures operands on Enable, produces one quotient
// bit per clock, flags divide-by-zero and keeps strobed display copies of the result.
module divisor_sequencial
    import divisor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic Clock,
    input logic Reset,
    divisor_sequencial_if.slave bus
);
    localparam int             CW        = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] asig;
    logic [WIDTH-1:0] bsig;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] qd;
    logic [WIDTH-1:0] rd;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic             div_zero;

    divisor_passo #(.WIDTH(WIDTH)) u_passo (
        .rem    (rem),
        .quo    (quo),
        .divisor(bsig),
        .rem_n  (rem_n),
        .quo_n  (quo_n)
    );

    // NOTE: every register updates with <= so all reads in this block see pre-edge values.
    always_ff @(posedge Clock) begin
        // NOTE: only a handful of flops, so the whole datapath is reset; an abort leaves no stale partials.
        if (Reset) begin
            state    <= IDLE;
            asig     <= '0;
            bsig     <= '0;
            rem      <= '0;
            quo      <= '0;
            q        <= '0;
            r        <= '0;
            qd       <= '0;
            rd       <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;

            // Display copy follows q, which already holds the new result during DONE.
            if (bus.Strobe && !busy) begin
                qd <= q;
                rd <= r;
            end

            case (state)
                IDLE: begin
                    if (bus.Enable) begin
                        asig  <= bus.A;
                        bsig  <= bus.B;
                        rem   <= '0;
                        quo   <= bus.A;
                        count <= LAST_STEP;
                        if (bus.B == '0) begin
                            q        <= '1;
                            r        <= bus.A;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    if (count == '0) begin
                        q        <= quo_n;
                        r        <= rem_n;
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Asig    = asig;
    assign bus.Bsig    = bsig;
    assign bus.Q       = q;
    assign bus.R       = r;
    assign bus.QD      = qd;
    assign bus.RD      = rd;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.DivZero = div_zero;
endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial at WIDTH=4 and WIDTH=8.
module tb_divisor_sequencial;

    typedef struct packed {
        logic       dz;
        logic [7:0] q;
        logic [7:0] r;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    divisor_sequencial_if #(.WIDTH(4)) if4 ();
    divisor_sequencial_if #(.WIDTH(8)) if8 ();

    divisor_sequencial #(.WIDTH(4)) u_dut4 (.Clock(Clock), .Reset(Reset), .bus(if4));
    divisor_sequencial #(.WIDTH(8)) u_dut8 (.Clock(Clock), .Reset(Reset), .bus(if8));

    int   checks = 0;
    int   errors = 0;
    exp_t q4[$];
    exp_t q8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic done_of(input int w);
        return (w == 4) ? if4.Done : if8.Done;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 4) ? if4.Busy : if8.Busy;
    endfunction

    // Result monitors: pop the expected completion whenever Done is seen.
    always @(negedge Clock) begin : mon4
        exp_t e;
        if (if4.Done === 1'b1) begin
            if (q4.size() == 0) check("done4_unexpected", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                check("q4", 32'(if4.Q), 32'(e.q));
                check("r4", 32'(if4.R), 32'(e.r));
                check("divzero4", 32'(if4.DivZero), 32'(e.dz));
            end
        end
    end

    always @(negedge Clock) begin : mon8
        exp_t e;
        if (if8.Done === 1'b1) begin
            if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("q8", 32'(if8.Q), 32'(e.q));
                check("r8", 32'(if8.R), 32'(e.r));
                check("divzero8", 32'(if8.DivZero), 32'(e.dz));
            end
        end
    end

    task automatic check_zero4(input string tag);
        check({tag, "_asig"}, 32'(if4.Asig), 0);
        check({tag, "_bsig"}, 32'(if4.Bsig), 0);
        check({tag, "_q"}, 32'(if4.Q), 0);
        check({tag, "_r"}, 32'(if4.R), 0);
        check({tag, "_qd"}, 32'(if4.QD), 0);
        check({tag, "_rd"}, 32'(if4.RD), 0);
        check({tag, "_busy"}, 32'(if4.Busy), 0);
        check({tag, "_done"}, 32'(if4.Done), 0);
        check({tag, "_divzero"}, 32'(if4.DivZero), 0);
    endtask

    // Single operation: push the expected result, pulse Enable, measure latency and Busy.
    task automatic op(input int w, input int a, input int b, input int eq, input int er, input bit edz);
        exp_t e;
        int   lat;
        int   busy_n;
        e.dz = edz;
        e.q  = eq[7:0];
        e.r  = er[7:0];
        @(posedge Clock); #1;
        if (w == 4) begin
            if4.A = a[3:0]; if4.B = b[3:0]; if4.Enable = 1'b1; q4.push_back(e);
        end else begin
            if8.A = a[7:0]; if8.B = b[7:0]; if8.Enable = 1'b1; q8.push_back(e);
        end
        @(posedge Clock); #1;
        if4.Enable = 1'b0;
        if8.Enable = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (done_of(w) !== 1'b1 && lat < 40) begin
            if (busy_of(w) === 1'b1) busy_n++;
            @(posedge Clock); #1;
            lat++;
        end
        check("latency", 32'(lat), (b == 0) ? 0 : 32'(w));
        check("busy_cycles", 32'(busy_n), (b == 0) ? 0 : 32'(w));
        check("busy_in_done", 32'(busy_of(w)), 0);
        @(posedge Clock); #1;
    endtask

    task automatic wait_done4(output int lat);
        lat = 0;
        while (if4.Done !== 1'b1 && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        check("wait_done4_bound", 32'(lat < 40), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   lat;
        int   dones;
        int   a;
        int   b;
        exp_t e;
        Reset = 1'b1;
        if4.A = '0; if4.B = '0; if4.Enable = 1'b0; if4.Strobe = 1'b0;
        if8.A = '0; if8.B = '0; if8.Enable = 1'b0; if8.Strobe = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_zero4("reset4");
        check("reset8_q", 32'(if8.Q), 0);
        check("reset8_busy", 32'(if8.Busy), 0);
        Reset = 1'b0;

        // Basic, divide-by-zero, and boundary operands.
        op(4, 13, 4, 3, 1, 1'b0);
        op(4, 9, 0, 15, 9, 1'b1);
        op(4, 15, 1, 15, 0, 1'b0);
        op(4, 3, 7, 0, 3, 1'b0);
        op(4, 0, 5, 0, 0, 1'b0);
        check("asig_after_0_5", 32'(if4.Asig), 0);
        check("bsig_after_0_5", 32'(if4.Bsig), 5);

        // Enable re-asserted with new operands during CALC is ignored.
        @(posedge Clock); #1;
        if4.A = 4'd13; if4.B = 4'd4; if4.Enable = 1'b1;
        e.dz = 1'b0; e.q = 8'd3; e.r = 8'd1; q4.push_back(e);
        @(posedge Clock); #1;
        if4.A = 4'd2; if4.B = 4'd1;
        @(posedge Clock); #1;
        check("ignore_asig_calc", 32'(if4.Asig), 13);
        @(posedge Clock); #1;
        if4.Enable = 1'b0;
        check("ignore_bsig_calc", 32'(if4.Bsig), 4);
        wait_done4(lat);
        @(posedge Clock); #1;
        check("ignore_asig_idle", 32'(if4.Asig), 13);
        check("ignore_busy_idle", 32'(if4.Busy), 0);

        // Strobe in IDLE, ignored in CALC, captures fresh result in DONE.
        op(4, 15, 1, 15, 0, 1'b0);
        if4.Strobe = 1'b1;
        @(posedge Clock); #1;
        if4.Strobe = 1'b0;
        check("strobe_idle_qd", 32'(if4.QD), 15);
        check("strobe_idle_rd", 32'(if4.RD), 0);
        if4.A = 4'd13; if4.B = 4'd4; if4.Enable = 1'b1;
        e.dz = 1'b0; e.q = 8'd3; e.r = 8'd1; q4.push_back(e);
        @(posedge Clock); #1;
        if4.Enable = 1'b0;
        if4.Strobe = 1'b1;
        @(posedge Clock); #1;
        if4.Strobe = 1'b0;
        check("strobe_calc_qd", 32'(if4.QD), 15);
        check("strobe_calc_rd", 32'(if4.RD), 0);
        wait_done4(lat);
        if4.Strobe = 1'b1;
        @(posedge Clock); #1;
        if4.Strobe = 1'b0;
        check("strobe_done_qd", 32'(if4.QD), 3);
        check("strobe_done_rd", 32'(if4.RD), 1);

        // Reset sampled on the second CALC edge aborts with no Done.
        @(posedge Clock); #1;
        if4.A = 4'd13; if4.B = 4'd4; if4.Enable = 1'b1;
        @(posedge Clock); #1;
        if4.Enable = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check_zero4("abort4");
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            if (if4.Done !== 1'b0) dones++;
        end
        check("abort_no_done", 32'(dones), 0);

        // WIDTH=8 directed and random sweep against A/B, A%B.
        op(8, 200, 7, 28, 4, 1'b0);
        op(8, 255, 0, 255, 255, 1'b1);
        op(8, 255, 255, 1, 0, 1'b0);
        op(8, 128, 200, 0, 128, 1'b0);
        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (b == 0) op(8, a, b, 255, a, 1'b1);
            else        op(8, a, b, a / b, a % b, 1'b0);
        end

        repeat (3) @(posedge Clock);
        #1;
        check("q4_drained", 32'(q4.size()), 0);
        check("q8_drained", 32'(q8.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
